// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-way round-robin burst arbiter.
// State encoding, requester indices and watchdog width helper.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // A zero-length counter is illegal, so a disabled watchdog keeps one bit.
  function automatic int cnt_w(input int to);
    return (to > 0) ? $clog2(to + 1) : 1;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two burst producers, the arbiter
// and the single downstream consumer.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in0_ready;

  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             in1_ready;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;

  logic             timeout_err;

  modport master (
    output in0_valid,
    output in0_data,
    output in0_last,
    input  in0_ready,
    output in1_valid,
    output in1_data,
    output in1_last,
    input  in1_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_src,
    output out_ready,
    input  timeout_err
  );

  modport slave (
    input  in0_valid,
    input  in0_data,
    input  in0_last,
    output in0_ready,
    input  in1_valid,
    input  in1_data,
    input  in1_last,
    output in1_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_src,
    input  out_ready,
    output timeout_err
  );

endinterface

// File: rtl/mux2_rr_arbiter_path.sv
// Combinational 2:1 datapath mux for the {last, data} beat.
// Select low picks requester 0.
module mux2_path #(
  parameter int W = 9
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin burst arbiter with a registered
// output stage and an idle watchdog on the locked burst.
module mux2_rr_arbiter
  import mux_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  mux2_rr_arbiter_if.slave bus
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam int TOP_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CNT_TOP = CW'(TOP_I);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_grant;
  logic             w_grant_nxt;
  logic             r_prio;
  logic             w_prio_nxt;
  logic [CW-1:0]    r_idle_cnt;
  logic [CW-1:0]    w_idle_cnt_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic             r_out_src;
  logic             r_timeout_err;

  logic             w_lock;
  logic             w_slot;
  logic             w_gnt_valid;
  logic             w_xfer;
  logic             w_expire;
  logic [WIDTH:0]   w_beat;

  mux2_path #(
    .W (WIDTH + 1)
  ) u_path (
    .i_sel (r_grant),
    .i_a   ({bus.in0_last, bus.in0_data}),
    .i_b   ({bus.in1_last, bus.in1_data}),
    .o_y   (w_beat)
  );

  // Ready depends only on registered state and out_ready.
  assign w_lock      = (r_state == LOCK);
  assign w_slot      = !r_out_valid || bus.out_ready;
  assign w_gnt_valid = r_grant ? bus.in1_valid
                               : bus.in0_valid;
  assign w_xfer      = w_lock && w_gnt_valid && w_slot;
  assign w_expire    = (TIMEOUT > 0) && w_lock &&
                       !w_gnt_valid &&
                       (r_idle_cnt == CNT_TOP);

  assign bus.in0_ready = w_lock && (r_grant == REQ0)
                         && w_slot;
  assign bus.in1_ready = w_lock && (r_grant == REQ1)
                         && w_slot;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_prio_nxt     = r_prio;
    w_idle_cnt_nxt = r_idle_cnt;
    unique case (r_state)
      IDLE: begin
        w_idle_cnt_nxt = '0;
        unique case (1'b1)
          bus.in0_valid && bus.in1_valid: begin
            w_grant_nxt = r_prio;
            w_state_nxt = LOCK;
          end
          bus.in0_valid && !bus.in1_valid: begin
            w_grant_nxt = REQ0;
            w_state_nxt = LOCK;
          end
          !bus.in0_valid && bus.in1_valid: begin
            w_grant_nxt = REQ1;
            w_state_nxt = LOCK;
          end
          default: ;
        endcase
      end
      LOCK: begin
        unique case (1'b1)
          w_xfer: begin
            w_idle_cnt_nxt = '0;
            if (w_beat[WIDTH]) begin
              w_state_nxt = IDLE;
              w_prio_nxt  = ~r_grant;
            end
          end
          w_expire: begin
            w_state_nxt    = IDLE;
            w_prio_nxt     = ~r_grant;
            w_idle_cnt_nxt = '0;
          end
          !w_gnt_valid && !w_expire: begin
            w_idle_cnt_nxt = (TIMEOUT > 0)
                           ? r_idle_cnt + 1'b1
                           : '0;
          end
          default: ;
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= REQ0;
      r_prio     <= REQ0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_prio     <= w_prio_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // A stalled beat holds every out_* field until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_src     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_expire;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_beat[WIDTH-1:0];
        r_out_last  <= w_beat[WIDTH];
        r_out_src   <= r_grant;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;
  assign bus.out_src     = r_out_src;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed bursts,
// expected beats queued up front, checked by a monitor.
module tb_mux2_rr_arbiter;

  logic clk;
  logic rst_n;
  bit   abort;
  bit   done0;

  int checks;
  int errors;
  int cyc;
  int to_cnt;
  int to_cyc;
  int t0;

  logic [9:0] exp_q[$];
  int         arr[$];

  mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux2_rr_arbiter #(
    .WIDTH   (8),
    .TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim still running at %0t", $time);
    $fatal(1);
  end

  function automatic logic [9:0] ex(input bit s, input bit l,
                                    input logic [7:0] d);
    return {s, l, d};
  endfunction

  // Output monitor: pops the scoreboard on every accepted beat.
  initial forever begin
    logic [9:0] e;
    logic [9:0] a;
    @(negedge clk);
    if (rst_n && bus.out_valid && bus.out_ready) begin
      a = {bus.out_src, bus.out_last, bus.out_data};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_beat: got unexpected src=%0d last=%0d data=0x%02h, required no beat",
                 a[9], a[8], a[7:0]);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL out_beat: got src=%0d last=%0d data=0x%02h, required src=%0d last=%0d data=0x%02h",
                   a[9], a[8], a[7:0], e[9], e[8], e[7:0]);
        end
      end
      arr.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic drive(input int p, input bit v,
                       input logic [7:0] d, input bit l);
    if (p == 0) begin
      bus.in0_valid = v;
      bus.in0_data  = d;
      bus.in0_last  = l;
    end else begin
      bus.in1_valid = v;
      bus.in1_data  = d;
      bus.in1_last  = l;
    end
  endtask

  function automatic bit rdy(input int p);
    return (p == 0) ? bus.in0_ready : bus.in1_ready;
  endfunction

  task automatic send(input int p, input int n,
                      input logic [7:0] base, input logic [7:0] step,
                      input bit endlast);
    for (int i = 0; i < n; i++) begin
      int k;
      bit got;
      k   = 0;
      got = 1'b0;
      drive(p, 1'b1, base + 8'(step * i),
            endlast && (i == n - 1));
      while (!got && k < 60 && !abort) begin
        @(negedge clk);
        if (rdy(p)) got = 1'b1;
        k++;
      end
      if (!got) begin
        if (!abort) begin
          checks++;
          errors++;
          $display("FAIL handshake_req%0d: beat %0d not accepted in %0d cycles, required acceptance",
                   p, i, k);
        end
        drive(p, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_arr(input int n, input string nm);
    int k;
    k = 0;
    while (arr.size() < n && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (arr.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d beats, required %0d", nm, arr.size(), n);
    end
  endtask

  task automatic chk_rst(input string nm);
    chk(nm, {bus.out_valid, bus.out_last, bus.out_src,
             bus.timeout_err, bus.in0_ready, bus.in1_ready,
             bus.out_data}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_rst("reset_state");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    done0 = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst("reset_state_init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single requester burst, latency and throughput
    arr.delete();
    exp_q.push_back(ex(0, 0, 8'h11));
    exp_q.push_back(ex(0, 0, 8'h22));
    exp_q.push_back(ex(0, 1, 8'h33));
    t0 = cyc;
    send(0, 3, 8'h11, 8'h11, 1'b1);
    wait_arr(3, "t1_beats");
    if (arr.size() >= 3) begin
      chk("t1_first_latency", arr[0] - t0, 2);
      chk("t1_beat2_cycle", arr[1] - arr[0], 1);
      chk("t1_beat3_cycle", arr[2] - arr[1], 1);
    end

    // contention fairness from reset
    do_reset();
    arr.delete();
    exp_q.push_back(ex(0, 0, 8'hA0));
    exp_q.push_back(ex(0, 1, 8'hA1));
    exp_q.push_back(ex(1, 0, 8'hB0));
    exp_q.push_back(ex(1, 1, 8'hB1));
    exp_q.push_back(ex(0, 0, 8'hA2));
    exp_q.push_back(ex(0, 1, 8'hA3));
    exp_q.push_back(ex(1, 0, 8'hB2));
    exp_q.push_back(ex(1, 1, 8'hB3));
    fork
      begin
        send(0, 2, 8'hA0, 8'h01, 1'b1);
        send(0, 2, 8'hA2, 8'h01, 1'b1);
      end
      begin
        send(1, 2, 8'hB0, 8'h01, 1'b1);
        send(1, 2, 8'hB2, 8'h01, 1'b1);
      end
    join
    wait_arr(8, "fair_beats");
    if (arr.size() >= 8) begin
      chk("fair_in_burst", arr[1] - arr[0], 1);
      chk("fair_bubble_1", arr[2] - arr[1], 2);
      chk("fair_bubble_2", arr[4] - arr[3], 2);
      chk("fair_bubble_3", arr[6] - arr[5], 2);
    end

    // back-pressure for five cycles mid-burst
    arr.delete();
    exp_q.push_back(ex(0, 0, 8'h41));
    exp_q.push_back(ex(0, 0, 8'h42));
    exp_q.push_back(ex(0, 0, 8'h43));
    exp_q.push_back(ex(0, 1, 8'h44));
    fork
      send(0, 4, 8'h41, 8'h01, 1'b1);
    join_none
    wait_arr(1, "bp_first");
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold", {bus.out_valid, bus.out_src,
                      bus.out_last, bus.out_data},
          {21'h0, 1'b1, 1'b0, 1'b0, 8'h42});
      chk("bp_in0_ready", bus.in0_ready, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_arr(4, "bp_beats");

    // asynchronous reset after two of four beats
    arr.delete();
    exp_q.push_back(ex(0, 0, 8'hC1));
    exp_q.push_back(ex(0, 0, 8'hC2));
    fork
      send(0, 4, 8'hC1, 8'h01, 1'b1);
    join_none
    wait_arr(2, "rst_first");
    #1 rst_n = 1'b0;
    #1 chk_rst("rst_async_clear");
    abort = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst("rst_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    abort = 1'b0;
    exp_q.push_back(ex(1, 1, 8'h91));
    t0 = cyc;
    send(1, 1, 8'h91, 8'h00, 1'b1);
    wait_arr(3, "rst_recover");
    if (arr.size() >= 3)
      chk("rst_in1_latency", arr[2] - t0, 2);

    // watchdog releases a stalled in1 burst
    arr.delete();
    exp_q.push_back(ex(1, 0, 8'h71));
    exp_q.push_back(ex(0, 0, 8'h61));
    exp_q.push_back(ex(0, 1, 8'h62));
    send(1, 1, 8'h71, 8'h00, 1'b0);
    send(0, 2, 8'h61, 8'h01, 1'b1);
    wait_arr(3, "wd_beats");
    chk("wd_pulses", to_cnt, 1);
    if (arr.size() >= 3) begin
      chk("wd_pulse_cycle", to_cyc - arr[0], 4);
      chk("wd_in0_cycle", arr[1] - arr[0], 6);
    end

    // in1 waits for the in0 burst to finish
    arr.delete();
    exp_q.push_back(ex(0, 0, 8'h51));
    exp_q.push_back(ex(0, 0, 8'h52));
    exp_q.push_back(ex(0, 1, 8'h53));
    exp_q.push_back(ex(1, 0, 8'h81));
    exp_q.push_back(ex(1, 1, 8'h82));
    done0 = 1'b0;
    fork
      begin
        send(0, 3, 8'h51, 8'h01, 1'b1);
        done0 = 1'b1;
      end
      begin
        @(posedge clk);
        #1;
        send(1, 2, 8'h81, 8'h01, 1'b1);
      end
      begin
        int k;
        k = 0;
        while (!done0 && k < 60) begin
          @(negedge clk);
          if (!done0 && bus.in1_valid)
            chk("guard_in1_ready", bus.in1_ready, 0);
          k++;
        end
      end
    join
    wait_arr(5, "guard_beats");

    repeat (5) @(posedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("timeout_total", to_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
